// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Defining UART_ARB_TAG_EN adds the TAG state used for per-grant header bytes.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LOAD  = 3'd2,
`ifdef UART_ARB_TAG_EN
    ST_DRAIN = 3'd3,
    ST_TAG   = 3'd4
`else
    ST_DRAIN = 3'd3
`endif
  } arb_state_e;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  function automatic int unsigned ID_W(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = ID_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  int unsigned idx;

  // Walk from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (req[IW'(idx)]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter among NUM_REQ producers.
// Optional feature macro: UART_ARB_TAG_EN (header byte 0xA0|id before each data byte).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned BUSY_TO = 15,
  localparam int unsigned IW      = ID_W(NUM_REQ)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 active,
  output logic                 err_to
);

  localparam int unsigned CW = 8;

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               en_d, active_d, err_d;
  logic [7:0]         din_d;
  logic [IW-1:0]      gid_d;
  logic [7:0]         sel_byte;
  logic               pick_valid;
  logic [IW-1:0]      pick_winner;
`ifdef UART_ARB_TAG_EN
  logic [7:0]         data_q, data_d;
  logic               pend_q, pend_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Byte offered by the registered winner.
  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_q == IW'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = '0;
    ack_d   = '0;
    en_d    = 1'b0;
    din_d   = uart_din;
    gid_d   = grant_id;
    err_d   = 1'b0;
`ifdef UART_ARB_TAG_EN
    data_d  = data_q;
    pend_d  = pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        ack_d  = NUM_REQ'(1) << win_q;
        gid_d  = win_q;
        last_d = win_q;
`ifdef UART_ARB_TAG_EN
        data_d  = sel_byte;
        pend_d  = 1'b1;
        state_d = ST_TAG;
`else
        din_d   = sel_byte;
        en_d    = 1'b1;
        state_d = ST_LOAD;
`endif
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        din_d   = TAG_BASE | 8'(grant_id);
        en_d    = 1'b1;
        state_d = ST_LOAD;
      end
`endif
      ST_LOAD: begin
        if (uart_tx_busy) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == CW'(BUSY_TO - 1)) begin
          // Transmitter never acknowledged: drop the byte (and any pending one).
          err_d   = 1'b1;
          state_d = ST_IDLE;
`ifdef UART_ARB_TAG_EN
          pend_d  = 1'b0;
`endif
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!uart_tx_busy) begin
          state_d = ST_IDLE;
`ifdef UART_ARB_TAG_EN
          if (pend_q) begin
            din_d   = data_q;
            en_d    = 1'b1;
            pend_d  = 1'b0;
            state_d = ST_LOAD;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      win_q    <= '0;
      cnt_q    <= '0;
      ack      <= '0;
      uart_en  <= 1'b0;
      uart_din <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      err_to   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      data_q   <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      ack      <= ack_d;
      uart_en  <= en_d;
      uart_din <= din_d;
      grant_id <= gid_d;
      active   <= active_d;
      err_to   <= err_d;
`ifdef UART_ARB_TAG_EN
      data_q   <= data_d;
      pend_q   <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_send model.
// Expected byte streams include the header byte when UART_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif
  localparam int FRAME = 20;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        uart_tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_to;

  int n_checks;
  int n_errors;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TO(15)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .active       (active),
    .err_to       (err_to)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // uart_send model: 2-flop edge detect on uart_en, busy for FRAME cycles.
  logic       busy_en;
  logic       en_s1, en_s2, en_d1;
  logic [7:0] din_d1;
  int         busy_cnt;
  int         frames_done;
  int         din_glitch;
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_s1        <= 1'b0;
      en_s2        <= 1'b0;
      en_d1        <= 1'b0;
      din_d1       <= '0;
      uart_tx_busy <= 1'b0;
      busy_cnt     <= 0;
    end else begin
      en_s1  <= uart_en;
      en_s2  <= en_s1;
      en_d1  <= uart_en;
      din_d1 <= uart_din;
      if (uart_en && en_d1 && uart_din != din_d1) din_glitch++;
      if (uart_tx_busy) begin
        busy_cnt <= busy_cnt + 1;
        if (busy_cnt == FRAME - 1) begin
          uart_tx_busy <= 1'b0;
          frames_done++;
        end
      end else if (busy_en && en_s1 && !en_s2) begin
        uart_tx_busy <= 1'b1;
        busy_cnt     <= 0;
        byte_q.push_back(uart_din);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'hA0 | {6'd0, id});
`endif
    exp_q.push_back(b);
  endtask

  task automatic check_bytes(input string tag);
    check_eq({tag, "_count"}, 32'(byte_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && byte_q.size() > 0)
      check_eq({tag, "_byte"}, 32'(byte_q.pop_front()), 32'(exp_q.pop_front()));
    byte_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    req      = '0;
    sys_rst  = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    byte_q.delete();
    exp_q.delete();
    frames_done = 0;
  endtask

  task automatic wait_ack(input string tag, output logic [3:0] a, output logic [1:0] g);
    a = '0;
    g = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (ack != 4'd0) begin
        a = ack;
        g = grant_id;
        break;
      end
    end
    check_eq({tag, "_ack_seen"}, 32'(a != 4'd0), 32'd1);
  endtask

  task automatic wait_idle(input string tag, output int extra_acks);
    logic done;
    done       = 1'b0;
    extra_acks = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (ack != 4'd0) extra_acks++;
      if (!active) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  logic [3:0] a;
  logic [1:0] g;
  int         extra;
  int         n;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    din_glitch  = 0;
    frames_done = 0;
    busy_en     = 1'b1;
    req         = '0;
    req_data    = '0;
    sys_rst     = 1'b1;

    // Reset values
    @(negedge sys_clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_en", 32'(uart_en), 32'd0);
    check_eq("rst_din", 32'(uart_din), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_err", 32'(err_to), 32'd0);

    // Single request from requester 2
    do_reset();
    req_data = 32'h0000_5A00 << 8;
    req      = 4'b0100;
    @(negedge sys_clk);
    check_eq("single_ack_early", 32'(ack), 32'd0);
    @(negedge sys_clk);
    check_eq("single_ack", 32'(ack), 32'h4);
    check_eq("single_gid", 32'(grant_id), 32'd2);
    check_eq("single_active", 32'(active), 32'd1);
`ifndef UART_ARB_TAG_EN
    check_eq("single_en", 32'(uart_en), 32'd1);
    check_eq("single_din", 32'(uart_din), 32'h5A);
`endif
    req = '0;
    wait_idle("single", extra);
    check_eq("single_extra_ack", 32'(extra), 32'd0);
    push_exp(2'd2, 8'h5A);
    check_bytes("single");

    // Contention: all four held, grant order 0,1,2,3,0
    do_reset();
    req_data = 32'h1312_1110;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("cont", a, g);
      check_eq("cont_ack", 32'(a), 32'(4'b0001 << (k % 4)));
      check_eq("cont_gid", 32'(g), 32'(k % 4));
      check_eq("cont_frames_before", 32'(frames_done), 32'(k * FPG));
      push_exp(2'(k % 4), 8'h10 + 8'(k % 4));
    end
    req = '0;
    wait_idle("cont", extra);
    check_bytes("cont");

    // Wrap-around: grant 3, then 4'b1001 serves 0 before 3
    do_reset();
    req_data = 32'hD300_00C0;
    req      = 4'b1000;
    wait_ack("wrap_a", a, g);
    check_eq("wrap_first", 32'(a), 32'h8);
    req = '0;
    wait_idle("wrap_a", extra);
    req = 4'b1001;
    wait_ack("wrap_b", a, g);
    check_eq("wrap_second", 32'(a), 32'h1);
    req[0] = 1'b0;
    wait_ack("wrap_c", a, g);
    check_eq("wrap_third", 32'(a), 32'h8);
    req = '0;
    wait_idle("wrap_c", extra);
    push_exp(2'd3, 8'hD3);
    push_exp(2'd0, 8'hC0);
    push_exp(2'd3, 8'hD3);
    check_bytes("wrap");

    // Busy timeout: transmitter never answers
    do_reset();
    busy_en  = 1'b0;
    req_data = 32'h0000_0077;
    req      = 4'b0001;
    wait_ack("to", a, g);
    req = '0;
    for (int i = 0; i < 4 && !uart_en; i++) @(negedge sys_clk);
    n = 0;
    while (uart_en && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    check_eq("to_en_cycles", 32'(n), 32'd15);
    check_eq("to_err_pulse", 32'(err_to), 32'd1);
    check_eq("to_active", 32'(active), 32'd0);
    @(negedge sys_clk);
    check_eq("to_err_clear", 32'(err_to), 32'd0);
    check_eq("to_en_low", 32'(uart_en), 32'd0);
    check_eq("to_no_bytes", 32'(byte_q.size()), 32'd0);
    busy_en = 1'b1;

    // Reset asserted during DRAIN
    do_reset();
    req_data = 32'h005A_0000;
    req      = 4'b0100;
    wait_ack("mid", a, g);
    req = '0;
    n   = 0;
    while (!(uart_tx_busy && !uart_en) && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    check_eq("mid_in_drain", 32'(uart_tx_busy && !uart_en), 32'd1);
    sys_rst = 1'b1;
    #1;
    check_eq("mid_rst_en", 32'(uart_en), 32'd0);
    check_eq("mid_rst_active", 32'(active), 32'd0);
    check_eq("mid_rst_gid", 32'(grant_id), 32'd0);
    check_eq("mid_rst_din", 32'(uart_din), 32'd0);
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    byte_q.delete();
    req_data = 32'h4400_0011;
    req      = 4'b1001;
    wait_ack("mid_after", a, g);
    check_eq("mid_after_grant", 32'(a), 32'h1);
    req = '0;
    wait_idle("mid_after", extra);
    check_eq("mid_after_extra_ack", 32'(extra), 32'd0);
    push_exp(2'd0, 8'h11);
    check_bytes("mid_after");

`ifdef UART_ARB_TAG_EN
    // Header byte then data byte, single ack
    do_reset();
    req_data = 32'h0033_0000;
    req      = 4'b0100;
    wait_ack("tag", a, g);
    check_eq("tag_ack", 32'(a), 32'h4);
    req = '0;
    wait_idle("tag", extra);
    check_eq("tag_extra_ack", 32'(extra), 32'd0);
    check_eq("tag_frames", 32'(frames_done), 32'd2);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'h33);
    check_bytes("tag");
`endif

    check_eq("din_stable", 32'(din_glitch), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_send` byte transmitter among `NUM_REQ` byte producers in the music UART player (status reporter, note logger, debug echo, etc.). It accepts one byte per grant through a req/ack handshake and latches it. It then drives the transmitter's level-sensitive `uart_en`/`uart_din` pair and tracks `uart_tx_busy` to sequence back-to-back frames without loss. It sits between the producers and the single `uart_send` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TO`, 15: cycles to wait for `uart_tx_busy` to rise after `uart_en` rises before aborting, 4..255.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `req` in `NUM_REQ`: per-requester byte request, level; held until ack.
- `req_data` in `8*NUM_REQ`: byte of requester i on bits [8i+7:8i]; stable while `req[i]`.
- `ack` out `NUM_REQ`: one-cycle pulse, byte of requester i latched.
- `uart_en` out 1: to `uart_send`; rising edge starts a frame.
- `uart_din` out 8: byte to `uart_send`; stable while `uart_en` is high.
- `uart_tx_busy` in 1: from `uart_send`.
- `grant_id` out `$clog2(NUM_REQ)`: requester currently being served.
- `active` out 1: high in any state other than IDLE.
- `err_to` out 1: one-cycle pulse on busy timeout.

## Operation
- States: IDLE, GRANT, TAG (macro only), LOAD, DRAIN.
- IDLE: if any `req` bit is set, select a winner by round-robin and go to GRANT. The search starts at `last+1` mod `NUM_REQ` and wraps. `last` resets to `NUM_REQ-1`, so requester 0 wins first.
- GRANT (1 cycle): latch the winner's byte, pulse `ack[winner]`, set `grant_id` and `last` to the winner. Next state is LOAD, or TAG when the macro is defined.
- LOAD: `uart_en`=1 with `uart_din` = the latched byte. Count cycles.
  - `uart_tx_busy`=1: drop `uart_en` and go to DRAIN.
  - Count reaches `BUSY_TO` first: drop `uart_en`, pulse `err_to`, go to IDLE. The byte is discarded.
- DRAIN: wait for `uart_tx_busy`=0, then go to IDLE, or to LOAD for the pending data byte after a tag.
- `req` is ignored in every state except IDLE. A requester that keeps `req` high after ack is served again only when its round-robin turn comes.
- If the winner drops `req` in the same cycle it is selected, the arbiter still serves it. Producers must not withdraw a request.

## Timing
- Reset values: `ack`=0, `uart_en`=0, `uart_din`=0, `grant_id`=0, `active`=0, `err_to`=0, state IDLE, `last`=`NUM_REQ-1`.
- Reset asserted mid-frame: return to IDLE immediately with `uart_en` low. No ack is replayed.
- Latency from `req` to `ack`: 2 cycles (IDLE decision, then GRANT).
- `uart_en` rises the cycle after GRANT (or after TAG).
- `uart_send` raises busy 2 cycles after `uart_en` rises, because of its 2-flop edge detector.
- `uart_en` must be low for at least 2 cycles before the next rising edge. DRAIN lasts a full frame, so this always holds.
- Frame-to-frame gap, back-to-back: 3 cycles of arbiter overhead plus the 2-cycle sync in `uart_send`.
- Simultaneous requests: only one grant per IDLE visit.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - GRANT goes to TAG.
  - TAG first sends header byte `8'hA0 | grant_id` through LOAD/DRAIN.
  - It then sends the data byte, so each grant produces 2 frames.
  - `ack` still pulses once, in GRANT.
  - A timeout on the tag aborts both bytes.
- `UART_ARB_TAG_EN` undefined: the TAG state and header logic are absent, and there is one frame per grant.

## Structure
- Shared package `uart_arb_pkg` holds:
  - the state enum;
  - `TAG_BASE = 8'hA0`;
  - `ID_W(n)` = `$clog2(n)`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `req` and `last`; outputs are `valid` and `winner`.

## Test plan
- Single request: `req`=4'b0100 with byte 8'h5A. Expect `ack`=4'b0100 two cycles later, `uart_en` rising, and the line carrying 0x5A (start bit, LSB first, stop bit). `active` returns to 0 after the frame.
- Contention: `req`=4'b1111 held with bytes 0x10..0x13. Grant order must be 0, 1, 2, 3, 0, each frame completing before the next `ack`.
- Wrap-around: after grant to 3, `req`=4'b1001. Expect grant 0, then 3.
- Timeout: tie `uart_tx_busy` to 0. Expect `uart_en` high for exactly `BUSY_TO` (15) cycles, then `err_to` pulses and the state returns to IDLE.
- Reset mid-frame: assert `sys_rst` during DRAIN. Expect all outputs at reset values on the same edge; after release, the next grant goes to requester 0.
- `UART_ARB_TAG_EN`: requester 2 sends 0x33. Expect the line to carry 0xA2, then 0x33, with a single `ack` pulse.
